// File: rtl/tqvp_gera_gray_reader.sv
// TinyQV peripheral: glitch-filtered Gray encoder reader with signed step count and error count.
// Optional GRAY_READER_SAT_EN makes the step count saturate instead of wrapping.
module tqvp_gera_gray_reader #(
    parameter int unsigned GRAY_W       = 4,
    parameter int unsigned FILT_DEFAULT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int unsigned STEP_W = 16;
    localparam int unsigned CNT_W  = 8;

    logic [GRAY_W-1:0] pos_q, pos_d, acc_q, acc_d, cand_q, cand_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d, filt_q, filt_d, errcnt_q, errcnt_d;
    logic [STEP_W-1:0] steps_q, steps_d, snap_q, snap_d;
    logic              valid_q, valid_d, err_sticky_q, err_sticky_d;
    logic              moved_q, moved_d, dir_q, dir_d, pulse_q, pulse_d;

    logic [GRAY_W-1:0] samp, bin, delta;
    logic              accept, is_up, is_dn;
    logic              wr_clear, wr_snap, wr_status, wr_filt;
    logic              unused_ui;

    assign unused_ui = &{1'b0, ui_in[7:GRAY_W]};

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        for (int unsigned k = 0; k < GRAY_W; k++) begin
            b[k] = ^(g >> k);
        end
        return b;
    endfunction

    // Filter, decode and register-bus next-state logic
    always_comb begin
        pos_d        = pos_q;
        acc_d        = acc_q;
        cand_d       = cand_q;
        fcnt_d       = fcnt_q;
        filt_d       = filt_q;
        errcnt_d     = errcnt_q;
        steps_d      = steps_q;
        snap_d       = snap_q;
        valid_d      = valid_q;
        err_sticky_d = err_sticky_q;
        moved_d      = moved_q;
        dir_d        = dir_q;
        pulse_d      = 1'b0;
        accept       = 1'b0;

        samp      = ui_in[GRAY_W-1:0];
        bin       = gray2bin(cand_q);
        delta     = bin - pos_q;
        is_up     = valid_q && (delta == GRAY_W'(1));
        is_dn     = valid_q && (delta == {GRAY_W{1'b1}});

        wr_clear  = data_write && (address == 4'h0);
        wr_snap   = data_write && (address == 4'h1);
        wr_status = data_write && (address == 4'h3);
        wr_filt   = data_write && (address == 4'h5);

        if (samp != cand_q) begin
            cand_d = samp;
            fcnt_d = '0;
        end else if (((cand_q != acc_q) || !valid_q) && (fcnt_q == filt_q)) begin
            accept = 1'b1;
        end else if (fcnt_q != {CNT_W{1'b1}}) begin
            fcnt_d = fcnt_q + CNT_W'(1);
        end

        if (wr_status) begin
            if (data_in[3]) err_sticky_d = 1'b0;
            if (data_in[2]) moved_d      = 1'b0;
        end

        if (wr_snap) begin
            snap_d = steps_q;
        end

        if (accept) begin
            acc_d   = cand_q;
            pos_d   = bin;
            valid_d = 1'b1;
            if (valid_q && !wr_clear) begin
                if (is_up || is_dn) begin
                    dir_d   = is_dn;
                    pulse_d = 1'b1;
                    moved_d = 1'b1;
`ifdef GRAY_READER_SAT_EN
                    if (is_up && (steps_q != 16'h7FFF)) steps_d = steps_q + STEP_W'(1);
                    if (is_dn && (steps_q != 16'h8000)) steps_d = steps_q - STEP_W'(1);
`else
                    steps_d = is_up ? steps_q + STEP_W'(1) : steps_q - STEP_W'(1);
`endif
                end else begin
                    err_sticky_d = 1'b1;
                    if (errcnt_q != {CNT_W{1'b1}}) errcnt_d = errcnt_q + CNT_W'(1);
                end
            end
        end

        if (wr_clear) begin
            steps_d      = '0;
            errcnt_d     = '0;
            err_sticky_d = 1'b0;
            moved_d      = 1'b0;
        end

        if (wr_filt) begin
            filt_d = data_in;
            fcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q        <= '0;
            acc_q        <= '0;
            cand_q       <= '0;
            fcnt_q       <= '0;
            filt_q       <= CNT_W'(FILT_DEFAULT);
            errcnt_q     <= '0;
            steps_q      <= '0;
            snap_q       <= '0;
            valid_q      <= 1'b0;
            err_sticky_q <= 1'b0;
            moved_q      <= 1'b0;
            dir_q        <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            acc_q        <= acc_d;
            cand_q       <= cand_d;
            fcnt_q       <= fcnt_d;
            filt_q       <= filt_d;
            errcnt_q     <= errcnt_d;
            steps_q      <= steps_d;
            snap_q       <= snap_d;
            valid_q      <= valid_d;
            err_sticky_q <= err_sticky_d;
            moved_q      <= moved_d;
            dir_q        <= dir_d;
            pulse_q      <= pulse_d;
        end
    end

    // Bit 0 is the UART TX pin on the carrier and must stay low
    assign uo_out = {4'(pos_q), err_sticky_q, dir_q, pulse_q, 1'b0};

    always_comb begin
        case (address)
            4'h0:    data_out = 8'(pos_q);
            4'h1:    data_out = snap_q[7:0];
            4'h2:    data_out = snap_q[15:8];
            4'h3:    data_out = {4'b0000, err_sticky_q, moved_q, dir_q, valid_q};
            4'h4:    data_out = errcnt_q;
            4'h5:    data_out = filt_q;
            default: data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_gera_gray_reader.sv
// Scoreboard bench for tqvp_gera_gray_reader: stimulus queues expected reads, a monitor compares them.
module tb_tqvp_gera_gray_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    tqvp_gera_gray_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // kind: 0 data_out, 1 uo_out, 2 step pulse count, 3 longest pulse run
    typedef struct {
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic rd_req = 1'b0;
    int   pulse_cnt = 0;
    int   run_len = 0;
    int   max_run = 0;

    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (uo_out[1]) begin
                pulse_cnt = pulse_cnt + 1;
                run_len   = run_len + 1;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (rd_req) begin
                n_cmp = n_cmp + 1;
                if (sb.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL scoreboard_empty: output presented with no expected entry");
                end else begin
                    e = sb.pop_front();
                    case (e.kind)
                        0:       act = data_out;
                        1:       act = uo_out;
                        2:       act = 8'(pulse_cnt);
                        default: act = 8'(max_run);
                    endcase
                    if (act !== e.exp) begin
                        n_fail = n_fail + 1;
                        $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, act, e.exp);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input logic [3:0] a, input logic [7:0] e, input string nm);
        address = a;
        sb.push_back('{kind, e, nm});
        rd_req = 1'b1;
        @(negedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(posedge clk);
        #1;
        data_write = 1'b0;
    endtask

    task automatic gray(input logic [3:0] g, input int n);
        ui_in = {4'h0, g};
        tick(n);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset state
        chk(1, 4'h0, 8'h00, "rst_uo_out");
        chk(0, 4'h5, 8'h03, "rst_filt");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);
        chk(0, 4'h3, 8'h00, "not_valid_edge3");
        chk(0, 4'h3, 8'h01, "valid_edge4");
        chk(0, 4'h0, 8'h00, "baseline_pos");
        chk(0, 4'h4, 8'h00, "baseline_errcnt");
        chk(2, 4'h0, 8'd0,  "baseline_no_pulse");

        // Forward walk 0 -> 1 -> 2 -> 3
        gray(4'h1, 8); chk(0, 4'h0, 8'h01, "fwd_pos1");
        gray(4'h3, 8); chk(0, 4'h0, 8'h02, "fwd_pos2");
        gray(4'h2, 8); chk(0, 4'h0, 8'h03, "fwd_pos3");
        wr(4'h1, 8'h00);
        chk(0, 4'h1, 8'h03, "fwd_snap_lo");
        chk(0, 4'h2, 8'h00, "fwd_snap_hi");
        chk(0, 4'h3, 8'h05, "fwd_status");
        chk(1, 4'h0, 8'h30, "fwd_uo_out");
        chk(2, 4'h0, 8'd3,  "fwd_pulses");

        // Reverse walk 3 -> 2 -> 1
        gray(4'h3, 8);
        gray(4'h1, 8);
        wr(4'h1, 8'h00);
        chk(0, 4'h1, 8'h01, "rev_snap_lo");
        chk(0, 4'h2, 8'h00, "rev_snap_hi");
        chk(0, 4'h3, 8'h07, "rev_status");
        chk(1, 4'h0, 8'h14, "rev_uo_out");
        chk(2, 4'h0, 8'd5,  "rev_pulses");

        // Back to 0, short glitch to Gray 6 ignored, then a real skip to 4
        gray(4'h0, 8);
        gray(4'h6, 3);
        gray(4'h0, 8);
        chk(0, 4'h0, 8'h00, "glitch_pos");
        chk(0, 4'h4, 8'h00, "glitch_errcnt");
        gray(4'h6, 8);
        chk(0, 4'h0, 8'h04, "skip_pos");
        chk(0, 4'h4, 8'h01, "skip_errcnt");
        chk(0, 4'h3, 8'h0F, "skip_status");
        chk(1, 4'h0, 8'h4C, "skip_uo_out");
        chk(2, 4'h0, 8'd6,  "skip_pulses");
        wr(4'h1, 8'h00);
        chk(0, 4'h1, 8'h00, "skip_snap_lo");

        // W1C of sticky bits, second error, then clear
        wr(4'h3, 8'h0C);
        chk(0, 4'h3, 8'h03, "w1c_status");
        gray(4'h0, 8);
        chk(0, 4'h4, 8'h02, "err2_errcnt");
        chk(0, 4'h3, 8'h0B, "err2_status");
        wr(4'h0, 8'h00);
        chk(0, 4'h4, 8'h00, "clr_errcnt");
        chk(0, 4'h0, 8'h00, "clr_pos");
        chk(0, 4'h3, 8'h03, "clr_status");

        // Step down from 0 wraps to 0xFFFF
        gray(4'h8, 8);
        wr(4'h1, 8'h00);
        chk(0, 4'h1, 8'hFF, "wrap_snap_lo");
        chk(0, 4'h2, 8'hFF, "wrap_snap_hi");
        chk(0, 4'h3, 8'h07, "wrap_status");
        chk(2, 4'h0, 8'd7,  "wrap_pulses");

        // filt=0: one extra sample accepts, single-sample glitch ignored
        wr(4'h5, 8'h00);
        chk(0, 4'h5, 8'h00, "filt0_read");
        gray(4'h9, 3);
        gray(4'hB, 1);
        gray(4'h9, 3);
        chk(0, 4'h0, 8'h0E, "filt0_pos");
        wr(4'h1, 8'h00);
        chk(0, 4'h1, 8'hFE, "filt0_snap_lo");
        chk(2, 4'h0, 8'd8,  "filt0_pulses");
        chk(3, 4'h0, 8'd1,  "pulse_width");
        chk(0, 4'h6, 8'h00, "unmapped_read");

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
